// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the RV32I datapath.
// master: controller side (samples instr/Zero, drives the control lines).
// slave:  datapath side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        Zero;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemToReg;
    logic [3:0]  ALUCtrl;
    logic        loadPC;
    logic        MemRead;
    logic        MemWrite;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instr, Zero,
        output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
               MemRead, MemWrite, illegal, state
    );

    modport slave (
        output instr, Zero,
        input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
               MemRead, MemWrite, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the RV32I datapath.
// Sequences IF/ID/EX/MEM/WB per instruction; all control outputs are
// registered Moore outputs except PCSrc, which gates the live Zero flag in WB.
// Optional feature: define MULTICYCLE_CTRL_ILLEGAL_HALT_EN to halt on an
// unsupported instruction (sticky illegal flag); otherwise it runs as a NOP.
module multicycle_ctrl #(
    parameter logic [31:0] IR_RESET = 32'h00000013
) (
    input logic                clk,
    input logic                rst,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        alu_src_q, alu_src_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        load_pc_q, load_pc_d;
    logic        beq_wb_q, beq_wb_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        dec_rtype, dec_itype, dec_lw, dec_sw, dec_beq, dec_legal;
    logic        dec_alu_src;
    logic [3:0]  dec_alu_ctrl;

    // Outputs are registered from the next state, so decoding looks at the IR
    // value that will be held next cycle rather than the current one.
    // Next IR: capture the fetched word on the IF->ID edge only.
    always_comb begin
        ir_d = (state_q == ST_IF) ? bus.instr : ir_q;
    end

    assign opcode = ir_d[6:0];
    assign funct3 = ir_d[14:12];
    assign funct7 = ir_d[31:25];

    // Instruction decode: class flags and ALU operation for supported encodings.
    always_comb begin
        dec_rtype    = 1'b0;
        dec_itype    = 1'b0;
        dec_lw       = 1'b0;
        dec_sw       = 1'b0;
        dec_beq      = 1'b0;
        dec_alu_ctrl = ALU_ADD;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    dec_rtype = (funct3 != 3'b011);
                    case (funct3)
                        3'b001:  dec_alu_ctrl = ALU_SLL;
                        3'b010:  dec_alu_ctrl = ALU_SLT;
                        3'b100:  dec_alu_ctrl = ALU_XOR;
                        3'b101:  dec_alu_ctrl = ALU_SRL;
                        3'b110:  dec_alu_ctrl = ALU_OR;
                        3'b111:  dec_alu_ctrl = ALU_AND;
                        default: dec_alu_ctrl = ALU_ADD;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        dec_rtype    = 1'b1;
                        dec_alu_ctrl = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_rtype    = 1'b1;
                        dec_alu_ctrl = ALU_SRA;
                    end
                end
            end
            7'b0010011: begin
                case (funct3)
                    3'b000: dec_itype = 1'b1;
                    3'b010: begin dec_itype = 1'b1; dec_alu_ctrl = ALU_SLT; end
                    3'b100: begin dec_itype = 1'b1; dec_alu_ctrl = ALU_XOR; end
                    3'b110: begin dec_itype = 1'b1; dec_alu_ctrl = ALU_OR;  end
                    3'b111: begin dec_itype = 1'b1; dec_alu_ctrl = ALU_AND; end
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            dec_itype    = 1'b1;
                            dec_alu_ctrl = ALU_SLL;
                        end
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            dec_itype    = 1'b1;
                            dec_alu_ctrl = ALU_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            dec_itype    = 1'b1;
                            dec_alu_ctrl = ALU_SRA;
                        end
                    end
                    default: dec_itype = 1'b0;
                endcase
            end
            7'b0000011: dec_lw  = (funct3 == 3'b010);
            7'b0100011: dec_sw  = (funct3 == 3'b010);
            7'b1100011: begin
                if (funct3 == 3'b000) begin
                    dec_beq      = 1'b1;
                    dec_alu_ctrl = ALU_SUB;
                end
            end
            default: dec_alu_ctrl = ALU_ADD;
        endcase
    end

    assign dec_legal   = dec_rtype | dec_itype | dec_lw | dec_sw | dec_beq;
    assign dec_alu_src = dec_itype | dec_lw | dec_sw;

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF:  state_d = ST_ID;
`ifdef MULTICYCLE_CTRL_ILLEGAL_HALT_EN
            ST_ID:  state_d = dec_legal ? ST_EX : ST_HALT;
            ST_HALT: state_d = ST_HALT;
`else
            ST_ID:  state_d = ST_EX;
            ST_HALT: state_d = ST_IF;
`endif
            ST_EX:  state_d = (dec_lw | dec_sw) ? ST_MEM : ST_WB;
            ST_MEM: state_d = ST_WB;
            ST_WB:  state_d = ST_IF;
            default: state_d = ST_IF;
        endcase
    end

    // Registered output values for the state being entered.
    always_comb begin
        logic in_exec;
        in_exec      = (state_d == ST_EX) || (state_d == ST_MEM) || (state_d == ST_WB);
        alu_src_d    = in_exec & dec_alu_src;
        alu_ctrl_d   = in_exec ? dec_alu_ctrl : ALU_ADD;
        mem_read_d   = (state_d == ST_MEM) & dec_lw;
        mem_write_d  = (state_d == ST_MEM) & dec_sw;
        reg_write_d  = (state_d == ST_WB) & (dec_rtype | dec_itype | dec_lw);
        mem_to_reg_d = (state_d == ST_WB) & dec_lw;
        load_pc_d    = (state_d == ST_WB);
        beq_wb_d     = (state_d == ST_WB) & dec_beq;
`ifdef MULTICYCLE_CTRL_ILLEGAL_HALT_EN
        illegal_d    = (state_d == ST_HALT);
`else
        illegal_d    = 1'b0;
`endif
    end

    // State, IR and output registers; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IF;
            ir_q         <= IR_RESET;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= ALU_ADD;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            load_pc_q    <= 1'b0;
            beq_wb_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            alu_src_q    <= alu_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            load_pc_q    <= load_pc_d;
            beq_wb_q     <= beq_wb_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.ALUSrc   = alu_src_q;
    assign bus.ALUCtrl  = alu_ctrl_q;
    assign bus.RegWrite = reg_write_q;
    assign bus.MemToReg = mem_to_reg_q;
    assign bus.MemRead  = mem_read_q;
    assign bus.MemWrite = mem_write_q;
    assign bus.loadPC   = load_pc_q;
    assign bus.illegal  = illegal_q;
    // Zero is only meaningful during WB, so it is gated live rather than registered.
    assign bus.PCSrc    = beq_wb_q & bus.Zero;

endmodule
